// File: rtl/sort4_if.sv
// sort4_if -- request/result bundle for the sort4_seq block.
//   start : load din and begin sorting (honoured only when not busy)
//   din   : four 4-bit elements, e_k = din[4k+3:4k]
//   dout  : sorted elements, same packing, element 0 first in sort order
//   busy  : comparisons in progress
//   done  : one-cycle pulse, dout/swaps valid
//   swaps : swap count of the last sort (0..6)
interface sort4_if;
  logic        start;
  logic [15:0] din;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic [2:0]  swaps;

  modport master (output start, din, input dout, busy, done, swaps);
  modport slave  (input start, din, output dout, busy, done, swaps);
endinterface

// File: rtl/sort4_seq.sv
// sort4_seq -- sequential bubble sort of four 4-bit unsigned elements using a
// single time-shared magnitude comparator, one adjacent compare per cycle,
// with early exit when a pass makes no swaps.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   io  : sort4_if.slave (start/din in, dout/busy/done/swaps out)
//   DESC: 0 = ascending, 1 = descending
module sort4_seq #(
  parameter bit DESC = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  sort4_if.slave io
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0][3:0] elem;
  logic [1:0]      pass, j;
  logic            flag;
  logic [2:0]      swaps;

  logic [3:0] ca, cb;
  logic       c_eq, c_lt, c_gt;
  logic       ooo, last_cmp, finish, load;

  // The one comparator: operands are muxed from the element file by j.
  assign ca   = elem[j];
  assign cb   = elem[j + 2'd1];
  assign c_eq = (ca == cb);
  assign c_lt = (ca < cb);
  assign c_gt = !(c_eq || c_lt);

  // Equal elements are never out of order, which keeps the sort stable.
  assign ooo      = DESC ? c_lt : c_gt;
  assign last_cmp = (j == (2'd2 - pass));
  // The current compare counts toward the pass's swap flag.
  assign finish   = last_cmp && (!(flag || ooo) || (pass == 2'd2));
  assign load     = (state != SORT) && io.start;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.start) state_nxt = SORT;
      SORT:    if (finish)   state_nxt = DONE;
      DONE:    state_nxt = io.start ? SORT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    io.busy = (state == SORT);
    io.done = (state == DONE);
  end

  assign io.dout  = elem;
  assign io.swaps = swaps;

  // datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem  <= '0;
      pass  <= '0;
      j     <= '0;
      flag  <= 1'b0;
      swaps <= '0;
    end else if (load) begin
      elem  <= io.din;
      pass  <= '0;
      j     <= '0;
      flag  <= 1'b0;
      swaps <= '0;
    end else if (state == SORT) begin
      if (ooo) begin
        elem[j]        <= cb;
        elem[j + 2'd1] <= ca;
        // At most six compares per sort, so the counter cannot exceed 6.
        swaps          <= swaps + 3'd1;
        flag           <= 1'b1;
      end
      if (last_cmp) begin
        if (!finish) begin
          // Start the next, one-shorter pass; the clear overrides any set above.
          pass <= pass + 2'd1;
          j    <= '0;
          flag <= 1'b0;
        end
      end else begin
        j <= j + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sort4_seq.sv
module tb_sort4_seq;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   sel   = 1'b0;

  sort4_if a_if ();
  sort4_if d_if ();

  sort4_seq #(.DESC(1'b0)) dut_a (.clk(clk), .rst(rst), .io(a_if.slave));
  sort4_seq #(.DESC(1'b1)) dut_d (.clk(clk), .rst(rst), .io(d_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_done, m_busy;
  logic [15:0] m_dout;
  logic [2:0]  m_swaps;
  assign m_done  = sel ? d_if.done  : a_if.done;
  assign m_busy  = sel ? d_if.busy  : a_if.busy;
  assign m_dout  = sel ? d_if.dout  : a_if.dout;
  assign m_swaps = sel ? d_if.swaps : a_if.swaps;

  task automatic drive(input bit desc, input logic s, input logic [15:0] d);
    if (desc) begin d_if.start = s; d_if.din = d; end
    else      begin a_if.start = s; a_if.din = d; end
  endtask

  // Start a sort and count edges (E0 = load) until done; checks result.
  task automatic run_sort(input bit desc, input logic [15:0] d, input logic [15:0] exp_d,
                          input logic [2:0] exp_s, input int exp_m, input string name);
    int cyc;
    bit bz_ok;
    sel = desc;
    @(negedge clk); drive(desc, 1'b1, d);
    @(posedge clk); #1; drive(desc, 1'b0, 16'h0);
    cyc = 0; bz_ok = 1'b1;
    while (!m_done && cyc < 20) begin
      if (!m_busy) bz_ok = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    total++; if (cyc !== exp_m) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, cyc, exp_m); end
    total++; if (m_dout !== exp_d) begin bad++; $display("FAIL %s dout got=%h exp=%h", name, m_dout, exp_d); end
    total++; if (m_swaps !== exp_s) begin bad++; $display("FAIL %s swaps got=%0d exp=%0d", name, m_swaps, exp_s); end
    total++; if (m_busy !== 1'b0 || !bz_ok) begin bad++; $display("FAIL %s busy got=%b bz_ok=%b exp busy=0 ok=1", name, m_busy, bz_ok); end
    @(posedge clk); #1;
    total++; if (m_done !== 1'b0) begin bad++; $display("FAIL %s done_pulse got=%b exp=0", name, m_done); end
    total++; if (m_dout !== exp_d) begin bad++; $display("FAIL %s dout_hold got=%h exp=%h", name, m_dout, exp_d); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0); drive(1'b1, 1'b0, 16'h0);
    #2;
    total++; if (a_if.dout !== 16'h0 || d_if.dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h/%h exp=0000", a_if.dout, d_if.dout); end
    total++; if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%b done=%b exp 0/0", a_if.busy, a_if.done); end
    total++; if (a_if.swaps !== 3'd0) begin bad++; $display("FAIL reset_swaps got=%0d exp=0", a_if.swaps); end
    // start while in reset must be ignored
    drive(1'b0, 1'b1, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_if.busy !== 1'b0 || a_if.dout !== 16'h0) begin bad++; $display("FAIL reset_start busy=%b dout=%h exp 0/0000", a_if.busy, a_if.dout); end
    @(negedge clk); drive(1'b0, 1'b0, 16'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL reset_release busy=%b exp=0", a_if.busy); end
  endtask

  task automatic test_sorted();   run_sort(1'b0, 16'h4321, 16'h4321, 3'd0, 3, "sorted");   endtask
  task automatic test_reversed(); run_sort(1'b0, 16'h1234, 16'h4321, 3'd6, 6, "reversed"); endtask
  task automatic test_dups();     run_sort(1'b0, 16'h5353, 16'h5533, 3'd1, 5, "dups");     endtask
  task automatic test_desc();     run_sort(1'b1, 16'h4321, 16'h1234, 3'd6, 6, "desc");     endtask
  task automatic test_desc_eq();  run_sort(1'b1, 16'h7777, 16'h7777, 3'd0, 3, "desc_eq");  endtask

  task automatic test_busy_start();
    int cyc;
    sel = 1'b0;
    @(negedge clk); drive(1'b0, 1'b1, 16'h1234);
    @(posedge clk); #1; drive(1'b0, 1'b0, 16'h0);
    @(posedge clk); #1;
    @(negedge clk); drive(1'b0, 1'b1, 16'hF0F0);
    @(posedge clk); #1; drive(1'b0, 1'b0, 16'h0);
    cyc = 2;
    while (!a_if.done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 6) begin bad++; $display("FAIL busy_start latency got=%0d exp=6", cyc); end
    total++; if (a_if.dout !== 16'h4321 || a_if.swaps !== 3'd6) begin bad++; $display("FAIL busy_start result got=%h/%0d exp=4321/6", a_if.dout, a_if.swaps); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 1'b0; seen = 1'b0;
    @(negedge clk); drive(1'b0, 1'b1, 16'h1234);
    @(posedge clk); #1; drive(1'b0, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    total++; if (a_if.dout !== 16'h0 || a_if.swaps !== 3'd0 || a_if.busy !== 1'b0 || a_if.done !== 1'b0)
      begin bad++; $display("FAIL reset_mid got dout=%h swaps=%0d busy=%b done=%b exp 0000/0/0/0", a_if.dout, a_if.swaps, a_if.busy, a_if.done); end
    repeat (4) begin @(posedge clk); #1; if (a_if.done) seen = 1'b1; end
    @(negedge clk); rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (a_if.done) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_done got=1 exp=0"); end
    run_sort(1'b0, 16'h1234, 16'h4321, 3'd6, 6, "after_reset");
  endtask

  task automatic test_back_to_back();
    int cyc;
    sel = 1'b0;
    @(negedge clk); drive(1'b0, 1'b1, 16'h4321);
    @(posedge clk); #1; drive(1'b0, 1'b0, 16'h0);
    cyc = 0;
    while (!a_if.done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 3 || a_if.dout !== 16'h4321) begin bad++; $display("FAIL b2b_first got lat=%0d dout=%h exp 3/4321", cyc, a_if.dout); end
    drive(1'b0, 1'b1, 16'h1234);   // start during DONE
    @(posedge clk); #1; drive(1'b0, 1'b0, 16'h0);
    total++; if (a_if.busy !== 1'b1 || a_if.done !== 1'b0) begin bad++; $display("FAIL b2b_reload got busy=%b done=%b exp 1/0", a_if.busy, a_if.done); end
    cyc = 0;
    while (!a_if.done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 6 || a_if.dout !== 16'h4321 || a_if.swaps !== 3'd6)
      begin bad++; $display("FAIL b2b_second got lat=%0d dout=%h swaps=%0d exp 6/4321/6", cyc, a_if.dout, a_if.swaps); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_reversed();
    test_dups();
    test_desc();
    test_desc_eq();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
